// File: rtl/hazard_scoreboard.sv
// Register hazard scoreboard: per-register pending-writer counters that
// decide whether the operand-fetch stage may issue or must stall. A
// same-cycle writeback bypasses a read hazard, and a flush discards every
// pending writer.
module hazard_scoreboard (
  input  logic        clk,
  input  logic        reset,
  input  logic        of_valid,
  input  logic        of_nop,
  input  logic [15:0] of_req,
  input  logic [15:0] of_prov,
  input  logic        wb_valid,
  input  logic [3:0]  wb_reg,
  input  logic        flush,
  output logic        of_stall,
  output logic        issue,
  output logic [15:0] busy,
  output logic [15:0] stall_cycles,
  output logic        wb_err
);

  typedef enum logic [1:0] {RUN, STALL, FLUSH} state_t;

  state_t            state;
  logic [15:0][1:0]  cnt;
  logic [15:0][1:0]  cnt_next;
  logic [15:0][1:0]  eff;
  logic [15:0]       wb_hit;
  logic [15:0]       eff_nz;
  logic [15:0]       eff_max;
  logic [15:0]       busy_next;
  logic              raw_hz;
  logic              ovf_hz;
  logic              can_go;

  // Effective counts after a same-cycle writeback, and the two hazard terms
  always_comb begin
    wb_hit  = '0;
    eff     = '0;
    eff_nz  = '0;
    eff_max = '0;
    for (int unsigned i = 0; i < 16; i++) begin
      wb_hit[i]  = wb_valid && (wb_reg == 4'(i)) && (cnt[i] != 2'd0);
      eff[i]     = cnt[i] - {1'b0, wb_hit[i]};
      eff_nz[i]  = (eff[i] != 2'd0);
      eff_max[i] = (eff[i] == 2'd3);
    end
    raw_hz = |(of_req & eff_nz);
    ovf_hz = |(of_prov & eff_max);
  end

  // Issue/stall decision for the presented slot
  always_comb begin
    can_go   = of_valid && !of_nop && !flush && !reset && (state != FLUSH);
    of_stall = can_go && (raw_hz || ovf_hz);
    issue    = can_go && !raw_hz && !ovf_hz;
  end

  // Next counter values; inc and dec in one cycle cancel, and neither can wrap
  always_comb begin
    cnt_next  = '0;
    busy_next = '0;
    for (int unsigned i = 0; i < 16; i++) begin
      cnt_next[i]  = cnt[i] + {1'b0, issue & of_prov[i]} - {1'b0, wb_hit[i]};
      busy_next[i] = (cnt_next[i] != 2'd0);
    end
  end

  // State, counters and registered status; busy mirrors the post-edge counters
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= RUN;
      cnt          <= '0;
      busy         <= '0;
      stall_cycles <= '0;
      wb_err       <= 1'b0;
    end else if (flush) begin
      state <= FLUSH;
      cnt   <= '0;
      busy  <= '0;
    end else begin
      cnt   <= cnt_next;
      busy  <= busy_next;
      state <= (state != FLUSH && of_stall) ? STALL : RUN;
      if (of_stall && stall_cycles != 16'hFFFF)
        stall_cycles <= stall_cycles + 16'd1;
      if (wb_valid && state != FLUSH && cnt[wb_reg] == 2'd0)
        wb_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: a table of directed vectors covering the
// stall, bypass, saturation, flush, spurious-writeback and reset cases,
// then randomized traffic checked against a pending-writer model.
module tb_hazard_scoreboard;

  logic        clk;
  logic        reset;
  logic        of_valid;
  logic        of_nop;
  logic [15:0] of_req;
  logic [15:0] of_prov;
  logic        wb_valid;
  logic [3:0]  wb_reg;
  logic        flush;
  logic        of_stall;
  logic        issue;
  logic [15:0] busy;
  logic [15:0] stall_cycles;
  logic        wb_err;

  hazard_scoreboard dut (
    .clk(clk), .reset(reset), .of_valid(of_valid), .of_nop(of_nop),
    .of_req(of_req), .of_prov(of_prov), .wb_valid(wb_valid), .wb_reg(wb_reg),
    .flush(flush), .of_stall(of_stall), .issue(issue), .busy(busy),
    .stall_cycles(stall_cycles), .wb_err(wb_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int failures = 0;

  // Reference model: number of outstanding writers per register
  int mcnt [16];
  bit m_in_flush;
  bit m_err;
  int m_sc;
  bit m_issue;
  bit m_stall;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_predict();
    bit raw = 0;
    bit ovf = 0;
    bit ok;
    for (int i = 0; i < 16; i++) begin
      int e;
      e = mcnt[i];
      if (wb_valid && wb_reg == 4'(i) && mcnt[i] > 0) e = e - 1;
      if (of_req[i] && e > 0) raw = 1;
      if (of_prov[i] && e == 3) ovf = 1;
    end
    ok = of_valid && !of_nop && !flush && !reset && !m_in_flush;
    m_stall = ok && (raw || ovf);
    m_issue = ok && !raw && !ovf;
  endtask

  task automatic model_update();
    if (reset) begin
      for (int i = 0; i < 16; i++) mcnt[i] = 0;
      m_in_flush = 0; m_err = 0; m_sc = 0;
    end else if (flush) begin
      for (int i = 0; i < 16; i++) mcnt[i] = 0;
      m_in_flush = 1;
    end else begin
      if (wb_valid && !m_in_flush) begin
        if (mcnt[wb_reg] == 0) m_err = 1;
        else mcnt[wb_reg] = mcnt[wb_reg] - 1;
      end
      if (m_issue)
        for (int i = 0; i < 16; i++) if (of_prov[i]) mcnt[i] = mcnt[i] + 1;
      if (m_stall && m_sc < 65535) m_sc = m_sc + 1;
      m_in_flush = 0;
    end
  endtask

  function automatic logic [15:0] model_busy();
    logic [15:0] b = '0;
    for (int i = 0; i < 16; i++) b[i] = (mcnt[i] != 0);
    return b;
  endfunction

  // Drive one cycle: inputs after the edge, comb outputs sampled mid-cycle,
  // registered outputs sampled 1 time unit after the following edge.
  logic s_issue, s_stall;
  task automatic step(input logic r, input logic v, input logic n,
                      input logic [15:0] rq, input logic [15:0] pv,
                      input logic wv, input logic [3:0] wr, input logic fl);
    reset = r; of_valid = v; of_nop = n; of_req = rq; of_prov = pv;
    wb_valid = wv; wb_reg = wr; flush = fl;
    #4;
    model_predict();
    s_issue = issue;
    s_stall = of_stall;
    @(posedge clk);
    model_update();
    #1;
  endtask

  typedef struct {
    logic        r, v, n;
    logic [15:0] rq, pv;
    logic        wv;
    logic [3:0]  wr;
    logic        fl;
    logic        e_issue, e_stall;
    logic [15:0] e_busy, e_sc;
    logic        e_err;
  } vec_t;

  vec_t tbl [30];

  initial begin
    // rst v  n  req       prov      wbv wbr   fl  | iss stl busy      sc     err
    tbl[0]  = '{1,1,0,16'h0000,16'h0001,0,4'd0,0, 0,0,16'h0000,16'd0,0}; // reset
    tbl[1]  = '{0,1,0,16'h0000,16'h0001,0,4'd0,0, 1,0,16'h0001,16'd0,0}; // writer r0
    tbl[2]  = '{0,1,0,16'h0001,16'h0000,0,4'd0,0, 0,1,16'h0001,16'd1,0}; // RAW stall
    tbl[3]  = '{0,1,0,16'h0001,16'h0000,0,4'd0,0, 0,1,16'h0001,16'd2,0};
    tbl[4]  = '{0,1,0,16'h0001,16'h0000,0,4'd0,0, 0,1,16'h0001,16'd3,0};
    tbl[5]  = '{0,1,0,16'h0001,16'h0000,1,4'd0,0, 1,0,16'h0000,16'd3,0}; // bypass r0
    tbl[6]  = '{0,1,0,16'h0000,16'h0004,0,4'd0,0, 1,0,16'h0004,16'd3,0}; // writer r2
    tbl[7]  = '{0,1,0,16'h0004,16'h0000,1,4'd2,0, 1,0,16'h0000,16'd3,0}; // bypass r2
    tbl[8]  = '{0,1,0,16'h0000,16'h8000,0,4'd0,0, 1,0,16'h8000,16'd3,0}; // r15 cnt1
    tbl[9]  = '{0,1,0,16'h0000,16'h8000,0,4'd0,0, 1,0,16'h8000,16'd3,0}; // cnt2
    tbl[10] = '{0,1,0,16'h0000,16'h8000,0,4'd0,0, 1,0,16'h8000,16'd3,0}; // cnt3
    tbl[11] = '{0,1,0,16'h0000,16'h8000,0,4'd0,0, 0,1,16'h8000,16'd4,0}; // ovf stall
    tbl[12] = '{0,1,0,16'h0000,16'h8000,1,4'd15,0,1,0,16'h8000,16'd4,0}; // wb lets it in
    tbl[13] = '{0,0,0,16'h0000,16'h0000,1,4'd15,0,0,0,16'h8000,16'd4,0}; // drain 2
    tbl[14] = '{0,0,0,16'h0000,16'h0000,1,4'd15,0,0,0,16'h8000,16'd4,0}; // drain 1
    tbl[15] = '{0,0,0,16'h0000,16'h0000,1,4'd15,0,0,0,16'h0000,16'd4,0}; // drain 0
    tbl[16] = '{0,1,0,16'h0000,16'h00FF,0,4'd0,0, 1,0,16'h00FF,16'd4,0}; // busy 00FF
    tbl[17] = '{0,1,0,16'h0000,16'h0001,0,4'd0,1, 0,0,16'h0000,16'd4,0}; // flush
    tbl[18] = '{0,1,0,16'h0000,16'h0001,1,4'd3,0, 0,0,16'h0000,16'd4,0}; // FLUSH cycle
    tbl[19] = '{0,1,0,16'h0000,16'h0002,0,4'd0,0, 1,0,16'h0002,16'd4,0}; // back to RUN
    tbl[20] = '{0,0,0,16'h0000,16'h0000,1,4'd5,0, 0,0,16'h0002,16'd4,1}; // spurious wb
    tbl[21] = '{0,0,0,16'h0000,16'h0000,0,4'd0,0, 0,0,16'h0002,16'd4,1}; // sticky
    tbl[22] = '{0,0,0,16'h0000,16'h0000,1,4'd1,0, 0,0,16'h0000,16'd4,1}; // clear r1
    tbl[23] = '{0,1,0,16'h0000,16'h0001,0,4'd0,0, 1,0,16'h0001,16'd4,1}; // writer r0
    tbl[24] = '{0,1,0,16'h0001,16'h0000,0,4'd0,0, 0,1,16'h0001,16'd5,1};
    tbl[25] = '{0,1,0,16'h0001,16'h0000,0,4'd0,0, 0,1,16'h0001,16'd6,1};
    tbl[26] = '{0,1,0,16'h0001,16'h0000,0,4'd0,0, 0,1,16'h0001,16'd7,1};
    tbl[27] = '{1,1,0,16'h0001,16'h0000,1,4'd0,1, 0,0,16'h0000,16'd0,0}; // reset mid-stall
    tbl[28] = '{0,1,0,16'h0001,16'h0000,0,4'd0,0, 1,0,16'h0000,16'd0,0}; // issues again
    tbl[29] = '{0,1,1,16'h0000,16'h0001,0,4'd0,0, 0,0,16'h0000,16'd0,0}; // nop slot

    for (int i = 0; i < 16; i++) mcnt[i] = 0;
    m_in_flush = 0; m_err = 0; m_sc = 0;
    reset = 1; of_valid = 0; of_nop = 0; of_req = '0; of_prov = '0;
    wb_valid = 0; wb_reg = '0; flush = 0;
    @(posedge clk); #1;

    for (int k = 0; k < 30; k++) begin
      step(tbl[k].r, tbl[k].v, tbl[k].n, tbl[k].rq, tbl[k].pv,
           tbl[k].wv, tbl[k].wr, tbl[k].fl);
      chk($sformatf("v%0d issue", k), 16'(s_issue), 16'(tbl[k].e_issue));
      chk($sformatf("v%0d of_stall", k), 16'(s_stall), 16'(tbl[k].e_stall));
      chk($sformatf("v%0d busy", k), busy, tbl[k].e_busy);
      chk($sformatf("v%0d stall_cycles", k), stall_cycles, tbl[k].e_sc);
      chk($sformatf("v%0d wb_err", k), 16'(wb_err), 16'(tbl[k].e_err));
    end

    // Randomized traffic against the model; reads/writes cluster on a few
    // registers so hazards, saturation and spurious writebacks all occur.
    for (int k = 0; k < 2000; k++) begin
      logic [15:0] rq, pv;
      logic [3:0]  wr;
      rq = ($urandom_range(0, 2) != 0) ? 16'(1 << $urandom_range(0, 5)) : 16'h0000;
      pv = ($urandom_range(0, 1) != 0) ? 16'(1 << $urandom_range(0, 5)) : 16'h0000;
      if ($urandom_range(0, 3) == 0) pv = pv | 16'(1 << $urandom_range(0, 5));
      wr = 4'($urandom_range(0, 6));
      step($urandom_range(0, 99) == 0, $urandom_range(0, 3) != 0,
           $urandom_range(0, 9) == 0, rq, pv, $urandom_range(0, 2) == 0, wr,
           $urandom_range(0, 29) == 0);
      chk("rnd issue", 16'(s_issue), 16'(m_issue));
      chk("rnd of_stall", 16'(s_stall), 16'(m_stall));
      chk("rnd busy", busy, model_busy());
      chk("rnd stall_cycles", stall_cycles, 16'(m_sc));
      chk("rnd wb_err", 16'(wb_err), 16'(m_err));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
